// File: rtl/mul_div_unit.sv
// Iterative MIPS HI/LO unit: shift-add multiply and restoring divide, one iteration per clock.
// Signed ops work on magnitudes and fix up signs when the final result is written.
module mul_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             divByZero
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, stateNext;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       opReg;
   logic             signA, signB;
   logic [WIDTH-1:0] absA, absB;
   logic [WIDTH:0]   rReg;
   logic [WIDTH-1:0] qReg;

   logic             accept, negA, negB, divZero, lastStep;
   logic [WIDTH-1:0] absANew, absBNew;
   logic [WIDTH:0]   mulSum, shR, divDiff, nextR;
   logic [WIDTH-1:0] nextQ;
   logic [2*WIDTH-1:0] fixed;

   // Sign fixup of the magnitude result; sA/sB are already zero for unsigned ops.
   function automatic logic [2*WIDTH-1:0] fixResult(input logic [1:0] opSel, input logic sA,
                                                    input logic sB, input logic [WIDTH-1:0] upper,
                                                    input logic [WIDTH-1:0] lower);
      logic [2*WIDTH-1:0] prod;
      logic [WIDTH-1:0]   quo;
      logic [WIDTH-1:0]   rem;
      prod = {upper, lower};
      quo  = lower;
      rem  = upper;
      if (opSel[1]) begin
         if (opSel[0]) begin
            if (sA ^ sB) quo = -lower;
            if (sA) rem = -upper;
         end else if (sA ^ sB) begin
            prod = -prod;
         end
      end
      return opSel[0] ? {rem, quo} : prod;
   endfunction

   assign accept   = start && (state != RUN);
   assign negA     = op[1] & a[WIDTH-1];
   assign negB     = op[1] & b[WIDTH-1];
   assign absANew  = negA ? -a : a;
   assign absBNew  = negB ? -b : b;
   assign divZero  = op[0] && (b == '0);
   assign lastStep = (state == RUN) && (cnt == CNT_W'(1));

   assign busy = (state == RUN);
   assign done = (state == DONE);

   // One iteration: multiply shifts {R,Q} right, divide shifts left and trial-subtracts.
   always_comb begin
      mulSum  = rReg + {1'b0, (qReg[0] ? absA : '0)};
      shR     = {rReg[WIDTH-1:0], qReg[WIDTH-1]};
      divDiff = shR - {1'b0, absB};
      if (opReg[0]) begin
         if (shR >= {1'b0, absB}) begin
            nextR = divDiff;
            nextQ = {qReg[WIDTH-2:0], 1'b1};
         end else begin
            nextR = shR;
            nextQ = {qReg[WIDTH-2:0], 1'b0};
         end
      end else begin
         nextR = {1'b0, mulSum[WIDTH:1]};
         nextQ = {mulSum[0], qReg[WIDTH-1:1]};
      end
      fixed = fixResult(opReg, signA, signB, nextR[WIDTH-1:0], nextQ);
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (start) stateNext = divZero ? DONE : RUN;
         RUN:     if (cnt == CNT_W'(1)) stateNext = DONE;
         DONE:    stateNext = start ? (divZero ? DONE : RUN) : IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         opReg     <= '0;
         signA     <= 1'b0;
         signB     <= 1'b0;
         absA      <= '0;
         absB      <= '0;
         rReg      <= '0;
         qReg      <= '0;
         hi        <= '0;
         lo        <= '0;
         divByZero <= 1'b0;
      end else if (accept) begin
         cnt   <= CNT_W'(WIDTH);
         opReg <= op;
         signA <= negA;
         signB <= negB;
         absA  <= absANew;
         absB  <= absBNew;
         rReg  <= '0;
         qReg  <= op[0] ? absANew : absBNew;
         if (divZero) begin
            hi        <= a;
            lo        <= '1;
            divByZero <= 1'b1;
         end
      end else if (state == RUN) begin
         cnt  <= cnt - CNT_W'(1);
         rReg <= nextR;
         qReg <= nextQ;
         if (lastStep) begin
            hi        <= fixed[2*WIDTH-1:WIDTH];
            lo        <= fixed[WIDTH-1:0];
            divByZero <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit at WIDTH=8: an integer reference model predicts HI/LO,
// the divide-by-zero flag, latency and busy length for every accepted operation.
module tb_mul_div_unit;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a, b;
   logic         busy, done, divByZero;
   logic [W-1:0] hi, lo;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           lat;
      int           busyExp;
      int           accCyc;
   } expect_t;

   expect_t sbQ[$];
   expect_t got;
   int      cyc = 0;
   int      busyCnt = 0;
   int      nChecks = 0;
   int      nPass = 0;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .divByZero(divByZero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] want);
      nChecks++;
      if (obs === want) nPass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
   endtask

   function automatic expect_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      expect_t e;
      int sx, sy, ux, uy, q, r;
      logic [2*W-1:0] p;
      sx = int'($signed(x));
      sy = int'($signed(y));
      ux = int'(x);
      uy = int'(y);
      e.dbz = 1'b0;
      e.lat = W + 1;
      e.busyExp = W;
      e.accCyc = 0;
      e.hi = '0;
      e.lo = '0;
      if (!o[0]) begin
         p = o[1] ? (2*W)'(sx * sy) : (2*W)'(ux * uy);
         e.hi = p[2*W-1:W];
         e.lo = p[W-1:0];
      end else if (y == '0) begin
         e.hi = x;
         e.lo = '1;
         e.dbz = 1'b1;
         e.lat = 1;
         e.busyExp = 0;
      end else begin
         if (o[1]) begin
            q = sx / sy;
            r = sx % sy;
         end else begin
            q = ux / uy;
            r = ux % uy;
         end
         e.hi = W'(r);
         e.lo = W'(q);
      end
      return e;
   endfunction

   // Called at a falling edge; drives one start pulse across the next rising edge.
   task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit expectAccept);
      expect_t e;
      start = 1'b1;
      op = o;
      a = x;
      b = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (expectAccept) begin
         e = model(o, x, y);
         e.accCyc = cyc - 1;
         sbQ.push_back(e);
      end
   endtask

   task automatic waitDone();
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      checkVal("doneSeen", 32'(seen), 1);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         busyCnt = 0;
      end else begin
         if (busy) busyCnt++;
         if (done) begin
            checkVal("sbDepth", 32'(sbQ.size() != 0), 1);
            if (sbQ.size() != 0) begin
               got = sbQ.pop_front();
               checkVal("hi", 32'(hi), 32'(got.hi));
               checkVal("lo", 32'(lo), 32'(got.lo));
               checkVal("divByZero", 32'(divByZero), 32'(got.dbz));
               checkVal("busyAtDone", 32'(busy), 0);
               checkVal("latency", cyc - got.accCyc, got.lat);
               checkVal("busyCycles", busyCnt, got.busyExp);
            end
            busyCnt = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   logic [1:0]   dirOp [10] = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd0, 2'd3, 2'd3};
   logic [W-1:0] dirA  [10] = '{8'd200, 8'd100, 8'hF9, 8'h80, 8'hFD, 8'h80, 8'h55, 8'd2, 8'h80, 8'h13};
   logic [W-1:0] dirB  [10] = '{8'd3, 8'd7, 8'd2, 8'hFF, 8'd5, 8'h80, 8'h00, 8'd2, 8'h00, 8'hFB};

   initial begin
      rst = 1'b1;
      start = 1'b0;
      op = '0;
      a = '0;
      b = '0;
      repeat (2) @(negedge clk);
      checkVal("rstBusy", 32'(busy), 0);
      checkVal("rstDone", 32'(done), 0);
      checkVal("rstHi", 32'(hi), 0);
      checkVal("rstLo", 32'(lo), 0);
      checkVal("rstDbz", 32'(divByZero), 0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         issue(dirOp[i], dirA[i], dirB[i], 1'b1);
         waitDone();
      end

      // Starts during RUN are dropped; a start in the DONE cycle is taken back-to-back.
      @(negedge clk);
      issue(2'd0, 8'd13, 8'd11, 1'b1);
      @(negedge clk);
      issue(2'd1, 8'd99, 8'd5, 1'b0);
      repeat (2) @(negedge clk);
      issue(2'd3, 8'hC4, 8'd3, 1'b0);
      waitDone();
      issue(2'd2, 8'hF0, 8'd7, 1'b1);
      waitDone();

      // Asynchronous reset in cycle 4 of a multiply.
      @(negedge clk);
      issue(2'd0, 8'd77, 8'd9, 1'b1);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checkVal("midRstBusy", 32'(busy), 0);
      checkVal("midRstDone", 32'(done), 0);
      checkVal("midRstHi", 32'(hi), 0);
      checkVal("midRstLo", 32'(lo), 0);
      checkVal("midRstDbz", 32'(divByZero), 0);
      sbQ.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue(2'd0, 8'd15, 8'd17, 1'b1);
      waitDone();

      for (int i = 0; i < 16; i++) begin
         logic [1:0]   rOp;
         logic [W-1:0] rA, rB;
         rOp = 2'($urandom_range(0, 3));
         rA = W'($urandom);
         rB = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         @(negedge clk);
         issue(rOp, rA, rB, 1'b1);
         waitDone();
      end

      repeat (2) @(negedge clk);
      checkVal("sbEmpty", sbQ.size(), 0);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
